// File: rtl/divu_iter_ctrl.sv
// rtl/divu_iter_ctrl.sv - restoring 32-bit DIV/DIVU controller driving a shared addsub32
module divu_iter_ctrl #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_aluc,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_carry,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int              CW   = $clog2(ITER);
    localparam logic [CW-1:0]   LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    // p: partial remainder, q: dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] mv;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic             accept;
    logic [WIDTH-1:0] md_in;
    logic [WIDTH-1:0] mv_in;
    logic [WIDTH-1:0] shifted;
    logic             succ;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] q_next;

    assign accept = (state == S_IDLE) && start;
    assign busy   = (state != S_IDLE);

    // Operand magnitudes for signed divide; -2^31 maps onto itself, which is the correct unsigned magnitude
    always_comb begin
        md_in = dividend;
        mv_in = divisor;
        if (is_signed && dividend[WIDTH-1]) begin
            md_in = ~dividend + 1'b1;
        end
        if (is_signed && divisor[WIDTH-1]) begin
            mv_in = ~divisor + 1'b1;
        end
    end

    // One restoring step: subtraction succeeds if the shifted remainder overflowed 32 bits or no borrow occurred
    always_comb begin
        shifted = {p[WIDTH-2:0], q[WIDTH-1]};
        succ    = p[WIDTH-1] | ~alu_carry;
        p_next  = succ ? alu_r : shifted;
        q_next  = {q[WIDTH-2:0], succ};
    end

    // Shared subtractor is only claimed while iterating; otherwise the normal ALU path owns it
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_aluc = 2'b00;
        if (state == S_ITER) begin
            alu_a    = shifted;
            alu_b    = mv;
            alu_aluc = 2'b01;
        end
    end

    // Next-state logic: divide-by-zero skips the iteration phase entirely
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_FIN : S_ITER;
                end
            end
            S_ITER: begin
                if (count == LAST) begin
                    state_next = S_FIN;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= '0;
            q      <= '0;
            mv     <= '0;
            count  <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz     <= 1'b0;
        end else if (accept) begin
            p     <= '0;
            count <= '0;
            if (divisor == '0) begin
                // Raw dividend is parked in q so FIN can return it as the remainder
                dz     <= 1'b1;
                q      <= dividend;
                mv     <= '0;
                sign_q <= 1'b0;
                sign_r <= 1'b0;
            end else begin
                dz     <= 1'b0;
                q      <= md_in;
                mv     <= mv_in;
                sign_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                sign_r <= is_signed & dividend[WIDTH-1];
            end
        end else if (state == S_ITER) begin
            p     <= p_next;
            q     <= q_next;
            count <= count + 1'b1;
        end
    end

    // Result registers: sign fix-up at FIN, done pulses for one cycle, div_by_zero held until next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                div_by_zero <= 1'b0;
            end
            if (state == S_FIN) begin
                done <= 1'b1;
                if (dz) begin
                    lo          <= '1;
                    hi          <= q;
                    div_by_zero <= 1'b1;
                end else begin
                    lo <= sign_q ? (~q + 1'b1) : q;
                    hi <= sign_r ? (~p + 1'b1) : p;
                end
            end
        end
    end

endmodule

// File: doc/divu_iter_ctrl.md
Name: divu_iter_ctrl

Overview:
- Sequential 32-bit divide controller for the EX stage.
- Implements MIPS DIV/DIVU by restoring division, one quotient bit per cycle.
- Does not contain a subtractor. It drives the shared addsub32 instance (a, b, aluc) and consumes that instance's r and carry outputs.
- Final quotient goes to LO and remainder to HI. The datapath writes both into the HI/LO registers when done pulses.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported, because it matches addsub32.
- ITER, 32, iteration count. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  single-cycle request; sampled only in IDLE
- is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
- dividend  in  32  operand rs; sampled with start
- divisor  in  32  operand rt; sampled with start
- alu_a  out  32  to addsub32 a
- alu_b  out  32  to addsub32 b
- alu_aluc  out  2  to addsub32 aluc
- alu_r  in  32  from addsub32 r
- alu_carry  in  1  from addsub32 carry (unsigned borrow, a<b)
- busy  out  1  operation in progress; the stall source for the pipeline
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- hi  out  32  remainder
- lo  out  32  quotient
- div_by_zero  out  1  set with done when divisor==0; held until next start

Behaviour:
Reset (async, rst_n=0):
- state=IDLE.
- busy=0, done=0, div_by_zero=0, hi=0, lo=0.
- Internal P, Q, count cleared.
- Reset mid-operation aborts the division with no done pulse.

States:
- IDLE: waits for start.
- ITER: 32 cycles, count 0..31.
- FIN: 1 cycle, sign fix and register outputs.
- Return to IDLE after FIN.

Edge E0 (start=1 in IDLE):
- If divisor==0: go to FIN with dz flag set.
- Otherwise latch magnitudes:
  - Md = |dividend| when is_signed and dividend[31]=1, else dividend.
  - Mv = same rule applied to divisor.
  - Latch sign_q = is_signed & (dividend[31]^divisor[31]) and sign_r = is_signed & dividend[31].
  - Q=Md, P=0, count=0, state=ITER.

ITER combinational drive:
- alu_a = {P[30:0], Q[31]}
- alu_b = Mv
- alu_aluc = 2'b01 (unsigned subtract)
- Let msb = P[31] and succ = msb | ~alu_carry.

Each ITER edge:
- P <= succ ? alu_r : {P[30:0], Q[31]}
- Q <= {Q[30:0], succ}
- count++
- When count==31, go to FIN.
- Rationale for msb: when msb=1 the shifted value is at least 2^32 > Mv, so the subtraction always succeeds and alu_r (mod 2^32) is exact.

FIN edge:
- lo <= sign_q ? -Q : Q
- hi <= sign_r ? -P : P
- done <= 1 for exactly one cycle; busy <= 0.
- div_by_zero case: lo <= 32'hFFFF_FFFF, hi <= dividend as latched at E0, div_by_zero <= 1.

Latency:
- Normal: start at E0, done high after E33 (33 cycles).
- Divide by zero: done high after E1.

busy:
- 1 from after E0 until the FIN edge.
- Never high in the same cycle as done.

Outside ITER:
- alu_a=0, alu_b=0, alu_aluc=2'b00. The datapath mux gives the normal ALU path priority whenever busy=0.

Other rules:
- start while busy or during FIN: ignored; hi/lo unaffected.
- start in the cycle done is high: accepted (state is IDLE).
- hi/lo hold their value until the next FIN. div_by_zero clears on the next accepted start.
- -2^31 / -1 (signed): quotient wraps to 0x8000_0000, remainder 0. No trap.
- Negation is internal two's complement; it does not use addsub32.

Test Plan:
- DIVU 100/7: start at E0 -> busy 1..33, done pulse after E33, lo=14, hi=2, div_by_zero=0; alu_aluc=01 throughout ITER.
- DIV 0xFFFF_FFF9 (-7) / 2: lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIV 7/0xFFFF_FFFE (-2): lo=0xFFFF_FFFD, hi=1.
- DIVU 0xFFFF_FFFF / 0x8000_0000 (exercises the msb path): lo=1, hi=0x7FFF_FFFF. DIVU 0xFFFF_FFFF/1: lo=0xFFFF_FFFF, hi=0.
- Divisor=0, dividend=0x1234: done after E1, lo=0xFFFF_FFFF, hi=0x1234, div_by_zero=1. Next valid start clears div_by_zero.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. Second start pulsed at cycle 10 of a DIVU 50/5: ignored; result lo=10, hi=0 at cycle 33.
- rst_n low at ITER cycle 15: busy, done, hi, lo all 0 immediately. After release, a new DIVU 9/3 gives lo=3, hi=0 with full 33-cycle latency.
